// File: rtl/binary_mul_share_arb.sv
// Round-robin front end that time-shares one pipelined signed multiplier among
// NUM_REQ clients and steers each product back to its owner via a tag pipeline.
module binary_mul_share_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 7,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    output logic                       mul_en,
    input  logic [2*WIDTH-2:0]         mul_p,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [2*WIDTH-2:0]         resp_p,
    output logic                       busy,
    output logic [15:0]                issue_cnt
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = IDW + 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [15:0]    issue_cnt_q, issue_cnt_d;
    logic           mul_en_q, mul_en_d;
    tag_t           tag_q [MUL_LAT];
    tag_t           tag_d [MUL_LAT];

    logic           found;
    logic [IDW-1:0] gnt_idx;
    logic [CW-1:0]  cand;

    // First valid requester at or after the pointer; no grants until mul_en is up,
    // which also keeps every handshake output quiet while in reset.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (mul_en_q && !found && req_valid[cand[IDW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
    end

    // Grant strobe and operand mux toward the multiplier.
    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (found) begin
            req_ready[gnt_idx] = 1'b1;
            mul_a = req_a[32'(gnt_idx)*WIDTH +: WIDTH];
            mul_b = req_b[32'(gnt_idx)*WIDTH +: WIDTH];
        end
    end

    // Next-state: pointer advance, issue counter, tag shift register.
    always_comb begin
        ptr_d       = ptr_q;
        issue_cnt_d = issue_cnt_q;
        mul_en_d    = 1'b1;
        for (int unsigned s = 0; s < MUL_LAT; s++) begin
            tag_d[s] = '0;
        end
        if (found) begin
            ptr_d       = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
        tag_d[0].vld = found;
        tag_d[0].id  = gnt_idx;
        for (int unsigned s = 1; s < MUL_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            issue_cnt_q <= '0;
            mul_en_q    <= 1'b0;
            for (int unsigned s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            issue_cnt_q <= issue_cnt_d;
            mul_en_q    <= mul_en_d;
            for (int unsigned s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    // Response decode straight from the last tag stage; product is a pass-through.
    always_comb begin
        resp_valid = '0;
        if (tag_q[MUL_LAT-1].vld) begin
            resp_valid[tag_q[MUL_LAT-1].id] = 1'b1;
        end
        busy = 1'b0;
        for (int unsigned s = 0; s < MUL_LAT; s++) begin
            busy = busy | tag_q[s].vld;
        end
    end

    assign resp_p    = mul_p;
    assign mul_en    = mul_en_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_binary_mul_share_arb.sv
// Scoreboard bench: two arbiter instances (MUL_LAT=1 and MUL_LAT=3), each with a
// behavioural multiplier; stimulus pushes expected responses, a monitor pops them.
module tb_binary_mul_share_arb;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 7;
    localparam int unsigned PW = 2*W-1;

    typedef struct {
        logic [NR-1:0] id;
        logic [PW-1:0] p;
        int unsigned   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NR-1:0]   rv [2];
    logic [NR-1:0]   rr [2];
    logic [NR-1:0]   rsv [2];
    logic [NR*W-1:0] ra [2];
    logic [NR*W-1:0] rb [2];
    logic [W-1:0]    ma [2];
    logic [W-1:0]    mb [2];
    logic            men [2];
    logic            bsy [2];
    logic [PW-1:0]   rp [2];
    logic [15:0]     ic [2];

    logic [PW-1:0]   pipe1;
    logic [PW-1:0]   pipe3 [3];

    int unsigned cyc = 0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t me;
    bit   mh;

    binary_mul_share_arb #(.NUM_REQ(NR), .WIDTH(W), .MUL_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[0]), .req_ready(rr[0]), .req_a(ra[0]), .req_b(rb[0]),
        .mul_a(ma[0]), .mul_b(mb[0]), .mul_en(men[0]), .mul_p(pipe1),
        .resp_valid(rsv[0]), .resp_p(rp[0]), .busy(bsy[0]), .issue_cnt(ic[0])
    );

    binary_mul_share_arb #(.NUM_REQ(NR), .WIDTH(W), .MUL_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[1]), .req_ready(rr[1]), .req_a(ra[1]), .req_b(rb[1]),
        .mul_a(ma[1]), .mul_b(mb[1]), .mul_en(men[1]), .mul_p(pipe3[2]),
        .resp_valid(rsv[1]), .resp_p(rp[1]), .busy(bsy[1]), .issue_cnt(ic[1])
    );

    // Behavioural signed multipliers with one and three register stages.
    always @(posedge clk) begin
        pipe1    <= PW'($signed(ma[0])) * PW'($signed(mb[0]));
        pipe3[0] <= PW'($signed(ma[1])) * PW'($signed(mb[1]));
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic set_op(input int inst, input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        ra[inst][idx*W +: W] = a;
        rb[inst][idx*W +: W] = b;
    endtask

    // One cycle of stimulus: drive valids, check the grant, optionally push the
    // expected response, then advance to just after the next rising edge.
    task automatic step(input int inst, input logic [NR-1:0] v, input int gid,
                        input logic [PW-1:0] p, input bit pu);
        exp_t e;
        logic [NR-1:0] g;
        rv[inst] = v;
        g = '0;
        if (gid >= 0) g[gid] = 1'b1;
        #1;
        chk($sformatf("req_ready%0d", inst), 32'(rr[inst]), 32'(g));
        if (pu) begin
            e.id  = g;
            e.p   = p;
            e.cyc = cyc + ((inst == 0) ? 1 : 3);
            if (inst == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented response must match the head of its queue.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rsv[k] != '0) begin
                mh = 1'b0;
                if (k == 0 && q0.size() > 0) begin
                    me = q0.pop_front();
                    mh = 1'b1;
                end else if (k == 1 && q1.size() > 0) begin
                    me = q1.pop_front();
                    mh = 1'b1;
                end
                if (!mh) begin
                    chk($sformatf("resp_unexpected%0d", k), 32'(rsv[k]), 32'd0);
                end else begin
                    chk($sformatf("resp_id%0d", k), 32'(rsv[k]), 32'(me.id));
                    chk($sformatf("resp_p%0d", k), 32'(rp[k]), 32'(me.p));
                    chk($sformatf("resp_cycle%0d", k), cyc, me.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rv[0] = '1;
        rv[1] = '1;
        ra[0] = '0; rb[0] = '0; ra[1] = '0; rb[1] = '0;
        set_op(0, 0, 7'sd3, 7'sd4);
        set_op(0, 1, -7'sd5, 7'sd12);
        set_op(0, 2, -7'sd7, -7'sd8);
        set_op(0, 3, 7'sd63, -7'sd2);
        set_op(1, 0, 7'sd63, 7'sd63);
        set_op(1, 1, -7'sd64, 7'sd1);
        set_op(1, 2, 7'sd7, -7'sd9);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ready%0d", k), 32'(rr[k]), 32'd0);
            chk($sformatf("rst_resp%0d", k), 32'(rsv[k]), 32'd0);
            chk($sformatf("rst_mul_en%0d", k), 32'(men[k]), 32'd0);
            chk($sformatf("rst_issue_cnt%0d", k), 32'(ic[k]), 32'd0);
            chk($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
            chk($sformatf("rst_mul_a%0d", k), 32'(ma[k]), 32'd0);
        end
        rst_n = 1'b1;
        rv[0] = '0;
        rv[1] = '0;
        @(posedge clk);
        #1;
        chk("mul_en_up0", 32'(men[0]), 32'd1);
        chk("mul_en_up1", 32'(men[1]), 32'd1);

        // All four valid for 8 cycles, pointer at 0.
        for (int r = 0; r < 2; r++) begin
            step(0, 4'b1111, 0, 13'sd12, 1'b1);
            step(0, 4'b1111, 1, -13'sd60, 1'b1);
            step(0, 4'b1111, 2, 13'sd56, 1'b1);
            step(0, 4'b1111, 3, -13'sd126, 1'b1);
        end
        chk("issue_cnt_rr", 32'(ic[0]), 32'd8);
        step(0, 4'b0000, -1, '0, 1'b0);

        // Single requester 1: -5 * 12.
        step(0, 4'b0010, 1, -13'sd60, 1'b1);
        chk("busy_inflight", 32'(bsy[0]), 32'd1);
        step(0, 4'b0000, -1, '0, 1'b0);
        chk("busy_idle", 32'(bsy[0]), 32'd0);
        chk("issue_cnt_single", 32'(ic[0]), 32'd9);

        // Pointer is 2: only 0 and 3 valid -> 3 then 0; then 1 wins with all valid.
        step(0, 4'b1001, 3, -13'sd126, 1'b1);
        step(0, 4'b1001, 0, 13'sd12, 1'b1);
        step(0, 4'b1111, 1, -13'sd60, 1'b1);
        step(0, 4'b0000, -1, '0, 1'b0);
        chk("issue_cnt_skip", 32'(ic[0]), 32'd12);

        // MUL_LAT=3 back-to-back.
        step(1, 4'b0111, 0, 13'd3969, 1'b1);
        step(1, 4'b0110, 1, -13'sd64, 1'b1);
        step(1, 4'b0100, 2, -13'sd63, 1'b1);
        repeat (4) step(1, 4'b0000, -1, '0, 1'b0);
        chk("busy_lat3_idle", 32'(bsy[1]), 32'd0);
        chk("issue_cnt_lat3", 32'(ic[1]), 32'd3);

        // Two tags in flight (pointer 3 -> grants 0, 1), then reset; nothing may return.
        step(1, 4'b0011, 0, '0, 1'b0);
        step(1, 4'b0010, 1, '0, 1'b0);
        rv[1] = '0;
        chk("busy_before_rst", 32'(bsy[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("busy_in_rst", 32'(bsy[1]), 32'd0);
        chk("issue_cnt_in_rst", 32'(ic[1]), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mul_en_after_rst", 32'(men[1]), 32'd1);
        repeat (4) step(1, 4'b0000, -1, '0, 1'b0);
        chk("busy_after_rst", 32'(bsy[1]), 32'd0);
        step(1, 4'b0100, 2, -13'sd63, 1'b1);
        repeat (4) step(1, 4'b0000, -1, '0, 1'b0);
        chk("issue_cnt_after_rst", 32'(ic[1]), 32'd1);

        for (int t = 0; t < 50 && (q0.size() + q1.size()) != 0; t++) @(posedge clk);
        chk("outstanding_responses", 32'(q0.size() + q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
